div_seq: RTL and testbench

Sequential, parametrised unsigned restoring divider for the ALU datapath. It produces an N-bit quotient and an N-bit remainder, one quotient bit per clock, controlled by a start/done handshake. It extends the combinational divide operation with a divide-by-zero path, registered outputs, and ALU-style status flags, so the ALU can issue a divide and wait for `done` without a long combinational path.

---
 rtl/div_seq_if.sv | 32 +++
 rtl/div_seq.sv | 110 +++++++++++
 tb/tb_div_seq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// ============================================================================
// Module   : div_seq_if
// Purpose  : Start/done handshake and operand/result bundle for div_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface div_seq_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] dividendo;
  logic [N-1:0] divisor;
  logic [N-1:0] cociente;
  logic [N-1:0] residuo;
  logic         busy;
  logic         done;
  logic         div_cero;
  logic         cero;

  modport master (
    output start, dividendo, divisor,
    input  cociente, residuo, busy, done, div_cero, cero
  );

  modport slave (
    input  start, dividendo, divisor,
    output cociente, residuo, busy, done, div_cero, cero
  );
endinterface

`default_nettype wire

// File: rtl/div_seq.sv
// ============================================================================
// Module   : div_seq
// Purpose  : Sequential unsigned restoring divider, one quotient bit per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_seq #(
  parameter int N = 4
) (
  input  logic     clk,
  input  logic     rst,
  div_seq_if.slave bus
);

  localparam int         c_CW   = $clog2(N);
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]      r_state;
  logic [c_CW-1:0] r_cnt;
  logic [N-1:0]    r_dvd;
  logic [N-1:0]    r_dvs;
  logic [N-1:0]    r_p;
  logic [N-1:0]    r_q;
  logic [N-1:0]    r_coc;
  logic [N-1:0]    r_res;
  logic            r_div_cero;
  logic            r_cero;

  logic [N:0]      w_shift;
  logic            w_ge;
  logic [N-1:0]    w_p_nxt;
  logic [N-1:0]    w_q_nxt;
  logic            w_dz;

  // The stored remainder is always below the divisor, so N bits hold it; only
  // the shifted value needs the extra bit for the compare and subtract.
  always_comb begin
    w_shift = {r_p, r_dvd[r_cnt]};
    w_ge    = (w_shift >= {1'b0, r_dvs});
    w_p_nxt = w_ge ? N'(w_shift - {1'b0, r_dvs}) : w_shift[N-1:0];
    w_q_nxt = r_q;
    w_q_nxt[r_cnt] = w_ge;
    w_dz    = (r_dvs == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_p        <= '0;
      r_q        <= '0;
      r_coc      <= '0;
      r_res      <= '0;
      r_div_cero <= 1'b0;
      r_cero     <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.start) begin
            r_dvd   <= bus.dividendo;
            r_dvs   <= bus.divisor;
            r_p     <= '0;
            r_q     <= '0;
            r_cnt   <= (bus.divisor == '0) ? '0 : c_CW'(N - 1);
            r_state <= c_RUN;
          end
        end
        c_RUN: begin
          // A zero divisor spends a single cycle here to give its fixed 2-cycle latency.
          if (w_dz) begin
            r_coc      <= '1;
            r_res      <= r_dvd;
            r_div_cero <= 1'b1;
            r_cero     <= 1'b0;
            r_state    <= c_DONE;
          end else begin
            r_p <= w_p_nxt;
            r_q <= w_q_nxt;
            if (r_cnt == '0) begin
              r_coc      <= w_q_nxt;
              r_res      <= w_p_nxt;
              r_div_cero <= 1'b0;
              r_cero     <= (w_q_nxt == '0);
              r_state    <= c_DONE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.cociente = r_coc;
  assign bus.residuo  = r_res;
  assign bus.busy     = (r_state != c_IDLE);
  assign bus.done     = (r_state == c_DONE);
  assign bus.div_cero = r_div_cero;
  assign bus.cero     = r_cero;

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// ============================================================================
// Module   : tb_div_seq
// Purpose  : Scoreboard bench for div_seq at N=4 and N=8.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_div_seq;

  typedef struct {
    int coc;
    int res;
    bit dz;
    bit cero;
  } exp_t;

  logic clk;
  logic rst;
  int   sel;
  int   total;
  int   passed;
  int   failed;
  exp_t sb[$];

  div_seq_if #(.N(4)) b4 ();
  div_seq_if #(.N(8)) b8 ();

  div_seq #(.N(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
  div_seq #(.N(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8));

  logic       done_s;
  logic       busy_s;
  logic       dz_s;
  logic       cero_s;
  logic [7:0] coc_s;
  logic [7:0] res_s;

  assign done_s = (sel == 0) ? b4.done     : b8.done;
  assign busy_s = (sel == 0) ? b4.busy     : b8.busy;
  assign dz_s   = (sel == 0) ? b4.div_cero : b8.div_cero;
  assign cero_s = (sel == 0) ? b4.cero     : b8.cero;
  assign coc_s  = (sel == 0) ? {4'b0, b4.cociente} : b8.cociente;
  assign res_s  = (sel == 0) ? {4'b0, b4.residuo}  : b8.residuo;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input bit st, input int a, input int b);
    if (s == 0) begin
      b4.start = st; b4.dividendo = 4'(a); b4.divisor = 4'(b);
    end else begin
      b8.start = st; b8.dividendo = 8'(a); b8.divisor = 8'(b);
    end
  endtask

  // Called just after a falling edge with the selected DUT idle.
  task automatic issue(input int s, input int a, input int b, input bit intrude);
    exp_t e;
    int   n, lat, nb, c;
    bit   seen;
    sel = s;
    n   = (s == 0) ? 4 : 8;
    if (b == 0) begin
      e.coc = (1 << n) - 1; e.res = a; e.dz = 1'b1; e.cero = 1'b0;
      lat = 2;
    end else begin
      e.coc = a / b; e.res = a % b; e.dz = 1'b0; e.cero = (a / b == 0);
      lat = n + 1;
    end
    sb.push_back(e);
    drive(s, 1'b1, a, b);
    seen = 1'b0;
    nb   = 0;
    c    = 1;
    while (c <= 40 && !seen) begin
      @(negedge clk);
      if (c == 1) drive(s, 1'b0, a, b);
      if (intrude && c == 2) drive(s, 1'b1, 7, 7);
      if (intrude && c == 3) drive(s, 1'b0, 7, 7);
      if (busy_s) nb++;
      if (done_s) begin
        seen = 1'b1;
        e = sb.pop_front();
        check($sformatf("latency %0d/%0d", a, b), c, lat);
        check($sformatf("cociente %0d/%0d", a, b), coc_s, e.coc);
        check($sformatf("residuo %0d/%0d", a, b), res_s, e.res);
        check($sformatf("div_cero %0d/%0d", a, b), dz_s, e.dz);
        check($sformatf("cero %0d/%0d", a, b), cero_s, e.cero);
        if (intrude) drive(s, 1'b1, 7, 7);
      end
      c++;
    end
    if (!seen) check("done timeout", 0, 1);
    @(negedge clk);
    drive(s, 1'b0, 0, 0);
    check($sformatf("busy cycles %0d/%0d", a, b), nb, lat);
    check($sformatf("idle after %0d/%0d", a, b), busy_s, 0);
    if (intrude) begin
      check("hold cociente", coc_s, e.coc);
      check("hold residuo", res_s, e.res);
    end
  endtask

  initial begin
    int  d1, d2;
    bit  saw;
    clk = 1'b0; rst = 1'b1; sel = 0;
    total = 0; passed = 0; failed = 0;
    drive(0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst cociente", b4.cociente, 0);
    check("rst residuo", b4.residuo, 0);
    check("rst busy", b4.busy, 0);
    check("rst done", b4.done, 0);
    check("rst div_cero", b4.div_cero, 0);
    check("rst cero", b4.cero, 0);
    @(negedge clk);

    issue(0, 13, 3, 1'b0);
    issue(0, 2, 5, 1'b0);
    issue(0, 15, 1, 1'b0);
    issue(0, 9, 0, 1'b0);
    issue(0, 8, 2, 1'b0);
    issue(1, 200, 7, 1'b0);
    issue(1, 255, 16, 1'b0);
    issue(1, 128, 255, 1'b0);
    issue(1, 77, 0, 1'b0);
    issue(0, 13, 3, 1'b1);

    // start held high: completions must be N+2 cycles apart
    sel = 0; d1 = -1; d2 = -1;
    drive(0, 1'b1, 13, 3);
    for (int c = 1; c <= 40 && d2 < 0; c++) begin
      @(negedge clk);
      if (done_s) begin
        if (d1 < 0) d1 = c; else d2 = c;
        check("held cociente", coc_s, 4);
      end
    end
    drive(0, 1'b0, 0, 0);
    check("held spacing", d2 - d1, 6);
    @(negedge clk);
    check("held idle", busy_s, 0);

    // reset during the third RUN cycle discards the division
    drive(0, 1'b1, 13, 3);
    @(negedge clk); drive(0, 1'b0, 13, 3);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst busy", busy_s, 0);
    check("midrst done", done_s, 0);
    check("midrst cociente", coc_s, 0);
    check("midrst residuo", res_s, 0);
    check("midrst div_cero", dz_s, 0);
    check("midrst cero", cero_s, 0);
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done_s) saw = 1'b1;
    end
    check("midrst no done", saw, 0);

    rst = 1'b1; drive(0, 1'b1, 6, 4);
    @(negedge clk);
    rst = 1'b0; drive(0, 1'b0, 0, 0);
    check("rst wins start", busy_s, 0);
    issue(0, 6, 4, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
